gate_preact_mac: RTL and testbench
==================================

GATE_PREACT_MAC -- requirements
Module: gate_preact_mac

Interface
REQ-001 SHALL have parameter WIDTH, default 24: data width of all fixed-point ports, two's complement.
REQ-002 SHALL have parameter FRAC, default 20: number of fractional bits, so 1.0 = 24'h100000.
REQ-003 SHALL have parameter N_IN, default 8: number of (x, w) pairs per dot product, range 1..256.
REQ-004 Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse that begins a dot product.
- i_bias  in  WIDTH  bias, sampled with i_start.
- i_valid  in  1  an (x, w) pair is present.
- i_x  in  WIDTH  input/hidden operand.
- i_w  in  WIDTH  weight operand.
- o_ready  out  1  the block accepts a pair this cycle.
- o_valid  out  1  pre-activation result valid, to tanh/sigmoid stage.
- i_ready  in  1  downstream accepts the result.
- o_data  out  WIDTH  pre-activation result.
- o_busy  out  1  the block is not in IDLE.

Function
REQ-005 SHALL implement the FSM IDLE -> ACC -> OUT -> IDLE.
REQ-006 IDLE: i_start=1 SHALL load acc = sign-extended i_bias << 0, clear the pair counter, and go to ACC next cycle.
REQ-007 Accumulator width SHALL be 2*WIDTH; the bias SHALL be sign-extended into it.
REQ-008 ACC: o_ready=1; each cycle with i_valid=1 SHALL add (i_x*i_w signed, full 2*WIDTH product, arithmetic shift right by FRAC) to acc and increment the counter.
REQ-009 When the N_IN-th pair is accepted, the block SHALL enter OUT on the next cycle, where o_valid=1 and o_data = narrow(acc).
REQ-010 With i_valid=0 in ACC, the block SHALL hold state without limit; gaps are allowed.
REQ-011 OUT: o_data and o_valid SHALL remain stable until i_ready=1; on o_valid&i_ready the block SHALL return to IDLE.
REQ-012 Latency SHALL be 1 cycle from last pair accepted to o_valid; minimum period per result is N_IN+2 cycles.
REQ-013 i_start outside IDLE SHALL be ignored; i_valid outside ACC SHALL be ignored and is never acknowledged (o_ready=0).
REQ-014 i_start and i_valid in the same IDLE cycle: only the start SHALL take effect; the pair is not consumed.
REQ-015 o_busy SHALL be 1 in ACC and OUT.

Reset
REQ-016 rst_n=0 SHALL force IDLE asynchronously, with acc=0, counter=0, o_valid=0, o_ready=0, o_busy=0, o_data=0.
REQ-017 Reset during ACC or OUT SHALL discard the partial result; nothing is output afterwards until a new i_start.

Configuration
REQ-018 Macro GATE_MAC_SATURATE_EN: defined -> narrow() SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1] (24'h800000..24'h7FFFFF); undefined -> narrow() SHALL truncate to acc[WIDTH-1:0] (wrap-around).

Structure
REQ-019 A shared package SHALL hold the FSM state enum, FRAC_ONE (1<<FRAC), and the saturation limits.
REQ-020 The signed fixed-point multiply-and-shift SHALL be a sub-module fxp_mult (WIDTH, FRAC parameters, combinational).

Verification
REQ-021 Basic: bias=0; 8 pairs of x=24'h100000, w=24'h080000 -> o_data=24'h400000 (4.0), exactly 1 cycle after the last pair.
REQ-022 Negative with bias: bias=24'h040000; 8 pairs of x=24'hF00000, w=24'h080000 -> o_data=24'hC40000 (-3.75).
REQ-023 Overflow: bias=0; 8 pairs of x=w=24'h200000 -> 24'h7FFFFF with GATE_MAC_SATURATE_EN, 24'h000000 without it.
REQ-024 Backpressure and gaps: i_valid toggled 1-0-1 during ACC and i_ready held low for 5 cycles in OUT -> result is unchanged and o_data is stable throughout; o_valid drops the cycle after the handshake.
REQ-025 Reset and ignores: rst_n pulsed after 3 pairs -> IDLE with outputs zero; an i_start issued while in OUT -> ignored, and the current result is delivered intact.

Source files
------------

// File: rtl/gate_preact_mac_pkg.sv
// Shared definitions for the gate pre-activation MAC: FSM states, default
// geometry, the fixed-point one and the narrow-result saturation limits.
package gate_preact_mac_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_FRAC  = 20;
    localparam int DEF_N_IN  = 8;

    localparam logic [DEF_WIDTH-1:0] FRAC_ONE = DEF_WIDTH'(1) << DEF_FRAC;
    localparam logic [DEF_WIDTH-1:0] SAT_MAX  = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] SAT_MIN  = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } gp_state_e;

endpackage

// File: rtl/gate_preact_mac_if.sv
// Operand/result handshake bundle of the gate pre-activation MAC.
// The slave modport is the MAC itself; the master side feeds pairs and takes results.
interface gate_preact_mac_if #(
    parameter int WIDTH = 24
);
    logic             i_start;
    logic [WIDTH-1:0] i_bias;
    logic             i_valid;
    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_w;
    logic             o_ready;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_busy;

    modport slave (
        input  i_start, i_bias, i_valid, i_x, i_w, i_ready,
        output o_ready, o_valid, o_data, o_busy
    );

    modport master (
        output i_start, i_bias, i_valid, i_x, i_w, i_ready,
        input  o_ready, o_valid, o_data, o_busy
    );
endinterface

// File: rtl/gate_preact_mac_fxp_mult.sv
// Signed fixed-point multiply: full 2*WIDTH product, arithmetic shift right by
// FRAC so the result keeps the operands' binary point. Purely combinational.
module fxp_mult #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 20
) (
    input  logic signed [WIDTH-1:0]   a_i,
    input  logic signed [WIDTH-1:0]   b_i,
    output logic signed [2*WIDTH-1:0] p_o
);
    logic signed [2*WIDTH-1:0] full_prod;

    assign full_prod = a_i * b_i;
    assign p_o       = full_prod >>> FRAC;
endmodule

// File: rtl/gate_preact_mac.sv
// Bias + N_IN-term signed fixed-point dot product feeding a tanh/sigmoid stage.
// Build option GATE_MAC_SATURATE_EN: clamp the narrowed result instead of wrapping.
module gate_preact_mac
    import gate_preact_mac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int N_IN  = DEF_N_IN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_preact_mac_if.slave      bus
);
    localparam int ACC_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_IN - 1);

    gp_state_e               state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] prod;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        narrow_acc;

    fxp_mult #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mult (
        .a_i (bus.i_x),
        .b_i (bus.i_w),
        .p_o (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pairs only land in ACC; a pair offered alongside i_start is left unconsumed.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    acc_d   = ACC_W'($signed(bus.i_bias));
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (bus.i_valid) begin
                    acc_d = acc_q + prod;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (bus.i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef GATE_MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_HI = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_LO = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    always_comb begin
        if (acc_q > ACC_HI) begin
            narrow_acc = ACC_HI[WIDTH-1:0];
        end else if (acc_q < ACC_LO) begin
            narrow_acc = ACC_LO[WIDTH-1:0];
        end else begin
            narrow_acc = acc_q[WIDTH-1:0];
        end
    end
`else
    assign narrow_acc = acc_q[WIDTH-1:0];
`endif

    // acc is frozen in OUT, so o_data is stable for as long as backpressure lasts.
    assign bus.o_ready = (state_q == ST_ACC);
    assign bus.o_valid = (state_q == ST_OUT);
    assign bus.o_busy  = (state_q != ST_IDLE);
    assign bus.o_data  = (state_q == ST_OUT) ? narrow_acc : '0;

endmodule

// File: tb/tb_gate_preact_mac.sv
// Self-checking bench for gate_preact_mac: directed and randomized dot products
// compared against an arithmetic reference model.
module tb_gate_preact_mac;
    import gate_preact_mac_pkg::*;

    localparam int WIDTH = 24;
    localparam int FRAC  = 20;
    localparam int N_IN  = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [WIDTH-1:0] xs [N_IN];
    logic [WIDTH-1:0] ws [N_IN];

    gate_preact_mac_if #(.WIDTH(WIDTH)) bus ();

    gate_preact_mac #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .N_IN  (N_IN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: real-valued sum in integer units, wrapped to the 2*WIDTH accumulator, then narrowed.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] bias);
        longint acc;
        longint hi;
        longint lo;
        acc = longint'($signed(bias));
        for (int i = 0; i < N_IN; i++) begin
            acc += (longint'($signed(xs[i])) * longint'($signed(ws[i]))) >>> FRAC;
        end
        acc = (acc <<< (64 - 2*WIDTH)) >>> (64 - 2*WIDTH);
        hi  = longint'($signed(SAT_MAX));
        lo  = longint'($signed(SAT_MIN));
`ifdef GATE_MAC_SATURATE_EN
        if (acc > hi) return SAT_MAX;
        if (acc < lo) return SAT_MIN;
`endif
        return acc[WIDTH-1:0];
    endfunction

    // One full transaction. gap_pct>=100 inserts exactly one idle cycle before every pair
    // after the first; start_in_out pulses i_start throughout the backpressure window;
    // junk_on_start presents a pair in the start cycle that must not be consumed.
    task automatic run_op(input string name, input logic [WIDTH-1:0] bias, input int gap_pct,
                          input int ready_wait, input bit start_in_out, input bit junk_on_start);
        logic [WIDTH-1:0] exp_data;
        logic [WIDTH-1:0] first;
        int ngap;
        exp_data = model(bias);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_bias  = bias;
        if (junk_on_start) begin
            bus.i_valid = 1'b1;
            bus.i_x     = FRAC_ONE;
            bus.i_w     = 24'h3FFFFF;
        end
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_bias  = $urandom;
        n_tests++;
        if (bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b want 1", name, bus.o_busy);
        end
        for (int k = 0; k < N_IN; k++) begin
            if (gap_pct >= 100) ngap = (k > 0) ? 1 : 0;
            else begin
                ngap = 0;
                while (ngap < 3 && $urandom_range(99) < gap_pct) ngap++;
            end
            for (int g = 0; g < ngap; g++) begin
                bus.i_valid = 1'b0;
                bus.i_x     = $urandom;
                bus.i_w     = $urandom;
                @(negedge clk);
                n_tests++;
                if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s gap_hold: ready=%b valid=%b want 1/0", name, bus.o_ready, bus.o_valid);
                end
            end
            bus.i_valid = 1'b1;
            bus.i_x     = xs[k];
            bus.i_w     = ws[k];
            if (k == N_IN - 1) begin
                n_tests++;
                if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s last_pair_accept: ready=%b valid=%b want 1/0", name, bus.o_ready, bus.o_valid);
                end
            end
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        n_tests++;
        if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s latency: valid=%b ready=%b want 1/0", name, bus.o_valid, bus.o_ready);
        end
        n_tests++;
        if (bus.o_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s result: got %h want %h", name, bus.o_data, exp_data);
        end
        first = bus.o_data;
        for (int c = 0; c < ready_wait; c++) begin
            bus.i_ready = 1'b0;
            if (start_in_out) begin
                bus.i_start = 1'b1;
                bus.i_bias  = $urandom;
            end
            @(negedge clk);
            bus.i_start = 1'b0;
            n_tests++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== first) begin
                n_fail++;
                $display("FAIL %s hold_stable: valid=%b data=%h want 1/%h", name, bus.o_valid, bus.o_data, first);
            end
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        n_tests++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_handshake: valid=%b busy=%b want 0/0", name, bus.o_valid, bus.o_busy);
        end
        $display("[TB] %s bias=%h data=%h expect=%h", name, bias, first, exp_data);
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({bus.o_valid, bus.o_ready, bus.o_busy} !== 3'b000 || bus.o_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: v/r/b=%b%b%b data=%h want 000/0",
                     bus.o_valid, bus.o_ready, bus.o_busy, bus.o_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_x = FRAC_ONE;
        bus.i_w = FRAC_ONE;
        @(negedge clk);
        bus.i_valid = 1'b0;
        n_tests++;
        if (bus.o_ready !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid_ignored: ready=%b busy=%b want 0/0", bus.o_ready, bus.o_busy);
        end
        $display("[TB] reset checked");
    endtask

    task automatic fill_const(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] w);
        for (int i = 0; i < N_IN; i++) begin
            xs[i] = x;
            ws[i] = w;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_IN; i++) begin
            xs[i] = $urandom;
            ws[i] = $urandom;
        end
    endtask

    task automatic test_basic();
        fill_const(24'h100000, 24'h080000);
        n_tests++;
        if (model(24'h000000) !== 24'h400000) begin
            n_fail++;
            $display("FAIL basic_model: got %h want 400000", model(24'h000000));
        end
        run_op("basic", 24'h000000, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_negative();
        fill_const(24'hF00000, 24'h080000);
        run_op("negative_bias", 24'h040000, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        fill_const(24'h200000, 24'h200000);
        run_op("overflow", 24'h000000, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_random();
        run_op("backpressure", $urandom, 100, 5, 1'b0, 1'b0);
    endtask

    task automatic test_start_in_out();
        fill_random();
        run_op("start_in_out", $urandom, 0, 3, 1'b1, 1'b0);
    endtask

    task automatic test_start_with_valid();
        fill_random();
        run_op("start_with_valid", $urandom, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_bias  = 24'h123456;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.i_valid = 1'b1;
            bus.i_x     = $urandom;
            bus.i_w     = $urandom;
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.o_valid, bus.o_ready, bus.o_busy} !== 3'b000 || bus.o_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: v/r/b=%b%b%b data=%h want 000/0",
                     bus.o_valid, bus.o_ready, bus.o_busy, bus.o_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2*N_IN; c++) begin
            bus.i_valid = 1'b1;
            bus.i_ready = 1'b1;
            @(negedge clk);
            n_tests++;
            if ({bus.o_valid, bus.o_ready, bus.o_busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_mid_quiet: v/r/b=%b%b%b want 000", bus.o_valid, bus.o_ready, bus.o_busy);
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        $display("[TB] reset during ACC checked");
        fill_random();
        run_op("after_reset", $urandom, 20, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_op("random", $urandom, 30, $urandom_range(3), 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_bias  = '0;
        bus.i_valid = 1'b0;
        bus.i_x     = '0;
        bus.i_w     = '0;
        bus.i_ready = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_overflow();
        test_backpressure();
        test_start_in_out();
        test_start_with_valid();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
